// File: rtl/wb_regfile_scoreboard.sv
// Writeback-side register file with bypassed read ports and a busy-bit scoreboard.
// The scoreboard stalls issue on RAW/WAW hazards against in-flight destinations.
module wb_regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    input  logic            issue_v_i,
    input  logic            issue_wb_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic [AW-1:0]   ra_addr_i,
    input  logic [AW-1:0]   rb_addr_i,
    input  logic            ra_use_i,
    input  logic            rb_use_i,
    output logic [XLEN-1:0] ra_data_o,
    output logic [XLEN-1:0] rb_data_o,
    output logic            hazard_o,
    output logic [NREG-1:0] busy_o,
    output logic [AW:0]     inflight_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     inflight_q;
    logic [AW:0]     inflight_d;

    logic wb_hit_a;
    logic wb_hit_b;
    logic wb_hit_rd;
    logic raw_a;
    logic raw_b;
    logic waw;
    logic accept;

    // A same-cycle writeback to a source or destination resolves its hazard via the bypass.
    assign wb_hit_a  = wb_en_i && (wb_addr_i == ra_addr_i);
    assign wb_hit_b  = wb_en_i && (wb_addr_i == rb_addr_i);
    assign wb_hit_rd = wb_en_i && (wb_addr_i == issue_rd_i);

    assign ra_data_o = wb_hit_a ? wb_data_i : regs[ra_addr_i];
    assign rb_data_o = wb_hit_b ? wb_data_i : regs[rb_addr_i];

    assign raw_a    = ra_use_i   && busy_q[ra_addr_i]  && !wb_hit_a;
    assign raw_b    = rb_use_i   && busy_q[rb_addr_i]  && !wb_hit_b;
    assign waw      = issue_wb_i && busy_q[issue_rd_i] && !wb_hit_rd;
    assign hazard_o = issue_v_i && (raw_a || raw_b || waw);
    assign accept   = issue_v_i && !hazard_o && !flush_i;

    // Clear is applied before set so a new producer to the retiring register keeps its bit.
    always_comb begin
        busy_d     = busy_q;
        inflight_d = '0;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (accept && issue_wb_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        for (int i = 0; i < NREG; i++) begin
            inflight_d = inflight_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            inflight_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            if (wb_en_i) begin
                regs[wb_addr_i] <= wb_data_i;
            end
        end
    end

    assign busy_o     = busy_q;
    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed self-checking bench for wb_regfile_scoreboard with hand-computed expectations.
module tb_wb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            issue_v;
    logic            issue_wb;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   ra_addr;
    logic [AW-1:0]   rb_addr;
    logic            ra_use;
    logic            rb_use;
    logic [XLEN-1:0] ra_data;
    logic [XLEN-1:0] rb_data;
    logic            hazard;
    logic [NREG-1:0] busy;
    logic [AW:0]     inflight;

    int checks = 0;
    int fails  = 0;

    wb_regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .flush_i    (flush),
        .issue_v_i  (issue_v),
        .issue_wb_i (issue_wb),
        .issue_rd_i (issue_rd),
        .ra_addr_i  (ra_addr),
        .rb_addr_i  (rb_addr),
        .ra_use_i   (ra_use),
        .rb_use_i   (rb_use),
        .ra_data_o  (ra_data),
        .rb_data_o  (rb_data),
        .hazard_o   (hazard),
        .busy_o     (busy),
        .inflight_o (inflight)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; combinational outputs settle 1ns later.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                 input logic fl, input logic iv, input logic iwb, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                 input logic rau, input logic rbu);
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        flush    = fl;
        issue_v  = iv;
        issue_wb = iwb;
        issue_rd = ird;
        ra_addr  = ra;
        rb_addr  = rb;
        ra_use   = rau;
        rb_use   = rbu;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 7, 1, 1);
        checkOutput("rst_ra",       ra_data, 32'h0);
        checkOutput("rst_rb",       rb_data, 32'h0);
        checkOutput("rst_hazard",   {31'b0, hazard}, 32'h0);
        checkOutput("rst_busy",     {16'b0, busy}, 32'h0);
        checkOutput("rst_inflight", {27'b0, inflight}, 32'h0);

        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 0, 0);
        checkOutput("bypass_ra", ra_data, 32'hDEADBEEF);
        checkOutput("bypass_rb_other", rb_data, 32'h0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
        checkOutput("stored_ra", ra_data, 32'hDEADBEEF);
        checkOutput("stored_rb", rb_data, 32'hDEADBEEF);

        // Producer for r2, then a consumer that stalls until r2 writes back.
        applyStimulus(0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0);
        checkOutput("issue_r2_hazard", {31'b0, hazard}, 32'h0);
        step();
        checkOutput("busy_r2",     {16'b0, busy}, 32'h0004);
        checkOutput("inflight_r2", {27'b0, inflight}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0);
        checkOutput("raw_hazard", {31'b0, hazard}, 32'h1);
        step();
        checkOutput("raw_hazard_hold", {31'b0, hazard}, 32'h1);
        checkOutput("raw_busy_hold",   {16'b0, busy}, 32'h0004);
        applyStimulus(1, 2, 32'h1234, 0, 1, 0, 0, 2, 0, 1, 0);
        checkOutput("raw_resolved", {31'b0, hazard}, 32'h0);
        checkOutput("raw_bypass",   ra_data, 32'h1234);
        step();
        checkOutput("raw_busy_clear", {16'b0, busy}, 32'h0);
        checkOutput("raw_inflight",   {27'b0, inflight}, 32'h0);

        // Operand B RAW path.
        applyStimulus(0, 0, 0, 0, 1, 1, 6, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 6, 0, 1);
        checkOutput("raw_b_hazard", {31'b0, hazard}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 6, 0, 0);
        checkOutput("raw_b_unused", {31'b0, hazard}, 32'h0);
        applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // WAW on r4.
        applyStimulus(0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        checkOutput("waw_hazard", {31'b0, hazard}, 32'h1);
        step();
        checkOutput("waw_busy_hold", {16'b0, busy}, 32'h0010);
        applyStimulus(1, 4, 32'hAAAA, 0, 1, 1, 4, 0, 0, 0, 0);
        checkOutput("waw_resolved", {31'b0, hazard}, 32'h0);
        step();
        checkOutput("waw_busy_set_wins", {16'b0, busy}, 32'h0010);
        checkOutput("waw_inflight",      {27'b0, inflight}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        checkOutput("waw_reg4", ra_data, 32'hAAAA);
        applyStimulus(1, 4, 32'hBBBB, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("r4_retired", {16'b0, busy}, 32'h0);

        // Flush squashes the set; the concurrent writeback still lands.
        applyStimulus(1, 1, 32'h55, 1, 1, 1, 9, 0, 0, 0, 0);
        checkOutput("flush_hazard", {31'b0, hazard}, 32'h0);
        step();
        checkOutput("flush_busy",     {16'b0, busy}, 32'h0);
        checkOutput("flush_inflight", {27'b0, inflight}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("flush_wb_r1", ra_data, 32'h55);

        // Register 0 is an ordinary register.
        applyStimulus(1, 0, 32'hF00D, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_writable", ra_data, 32'hF00D);

        // Unbusy writeback and new producer to the same register in one cycle.
        applyStimulus(1, 7, 32'h77, 0, 1, 1, 7, 0, 0, 0, 0);
        step();
        checkOutput("setclr_busy", {16'b0, busy}, 32'h0080);
        applyStimulus(1, 7, 32'h78, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Fill r1..r3 then reset with activity on the same edge.
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, AW'(r), 0, 0, 0, 0);
            step();
        end
        checkOutput("fill_busy",     {16'b0, busy}, 32'h000E);
        checkOutput("fill_inflight", {27'b0, inflight}, 32'h3);
        rst = 1'b1;
        applyStimulus(1, 5, 32'h99, 0, 1, 1, 6, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 4, 0, 0);
        checkOutput("rst2_r5",       ra_data, 32'h0);
        checkOutput("rst2_r4",       rb_data, 32'h0);
        checkOutput("rst2_busy",     {16'b0, busy}, 32'h0);
        checkOutput("rst2_inflight", {27'b0, inflight}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rst2_r1", ra_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- Receiving end of the EX-stage writeback interface: consumes wb_en / rd_addr / result from EX and commits them into a 16-entry register file.
- Supplies operand values back to the issue side through two bypassed read ports.
- Tracks in-flight destination registers in a scoreboard and raises a hazard stall so issue never reads a stale operand or reorders writes to one register.
- Sits between decode/issue (upstream of EX) and EX's writeback outputs.

Parameters:
XLEN, 32, data width of registers and writeback bus
NREG, 16, number of architectural registers
AW, 4, register address width (log2 NREG)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wb_en_i  in  1  EX writeback enable (EX wb_en_o)
wb_addr_i  in  AW  writeback destination (EX rd_addr_o)
wb_data_i  in  XLEN  writeback value (EX result_o)
flush_i  in  1  taken branch from EX (EX branch_en_o); squashes the issue slot this cycle
issue_v_i  in  1  issue side presents an instruction
issue_wb_i  in  1  presented instruction writes a register (rsv)
issue_rd_i  in  AW  destination of presented instruction
ra_addr_i  in  AW  operand A address (rd field)
rb_addr_i  in  AW  operand B address (rs field)
ra_use_i  in  1  operand A is a real source
rb_use_i  in  1  operand B is a real source
ra_data_o  out  XLEN  operand A value
rb_data_o  out  XLEN  operand B value
hazard_o  out  1  stall issue this cycle
busy_o  out  NREG  scoreboard bit vector
inflight_o  out  AW+1  count of set busy bits

Behaviour:
- Reset (rst=1 at edge): all NREG registers <= 0, busy <= 0. After reset: ra_data_o/rb_data_o = 0 for any address unless bypassed, hazard_o = 0, busy_o = 0, inflight_o = 0. Reset overrides any same-cycle write or issue.
- Write: rising edge with wb_en_i=1 writes wb_data_i to reg[wb_addr_i]; all NREG entries are writable (no hardwired zero).
- Read: combinational, 0-cycle latency. If wb_en_i && wb_addr_i==ra_addr_i, ra_data_o = wb_data_i (write-through bypass), else reg[ra_addr_i]. Same rule for rb. Both ports may address the same register.
- Accept: accept = issue_v_i & ~hazard_o & ~flush_i.
- Scoreboard set: accept & issue_wb_i sets busy[issue_rd_i] at the edge.
- Scoreboard clear: wb_en_i clears busy[wb_addr_i] at the edge.
- Simultaneous set and clear of the same index: set wins; the bit stays 1 for the new producer.
- wb_en_i to an address whose busy bit is 0 is legal: write happens, busy unchanged.
- Hazard:
  - hazard_o = issue_v_i & (RAW_a | RAW_b | WAW).
  - RAW_a = ra_use_i & busy[ra_addr_i] & ~(wb_en_i & wb_addr_i==ra_addr_i). RAW_b likewise for rb.
  - WAW = issue_wb_i & busy[issue_rd_i] & ~(wb_en_i & wb_addr_i==issue_rd_i).
  - A writeback in the same cycle resolves the hazard through the bypass.
  - hazard_o ignores flush_i.
- Flush: flush_i=1 suppresses the scoreboard set for that cycle. It does not clear existing busy bits; those belong to older instructions that still write back. The register write from wb_en_i in the same cycle still happens.
- inflight_o: registered popcount of busy, updated in the same edge as busy. Range 0..NREG.
- Invariant: WAW stall guarantees at most one outstanding producer per register, so one busy bit per register is sufficient.

Test Plan:
- Reset, then read ra=3, rb=7 -> both 0, hazard_o=0, busy_o=0, inflight_o=0.
- wb_en=1, addr=5, data=0xDEADBEEF with ra_addr=5 in the same cycle -> ra_data_o=0xDEADBEEF immediately. Next cycle, wb_en=0 -> ra_data_o still 0xDEADBEEF.
- Issue rd=2 (issue_wb=1), next cycle issue ra_addr=2 ra_use=1:
  - hazard_o=1 until wb_en=1 addr=2 data=0x1234.
  - In the wb cycle: hazard_o=0, ra_data_o=0x1234, busy_o[2] -> 0.
- busy[4]=1, issue_wb=1 rd=4, no writeback -> hazard_o=1 (WAW). Same cycle with wb addr=4 -> accepted, busy[4] stays 1, inflight_o unchanged.
- flush_i=1 with an unhazarded issue rd=9 -> busy_o[9] stays 0, inflight_o unchanged. A concurrent wb addr=1 data=0x55 is still written.
- Set busy for regs 1,2,3 (inflight_o=3), assert rst with concurrent wb and issue -> next cycle all regs 0, busy_o=0, inflight_o=0.
